uart_tx_ctrl_param: RTL and testbench

//  Parametrised UART transmit controller: FSM, serializer and parity generator in one block.

---
 rtl/uart_tx_pkg.sv | 26 ++
 rtl/uart_tx_serializer.sv | 48 ++++
 rtl/uart_tx_ctrl_param.sv | 116 +++++++++++
 tb/tb_uart_tx_ctrl_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART TX controller: Gray-style FSM state codes,
// parity type encodings and the parity helper.
package uart_tx_pkg;

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_START  = 3'b001;
  localparam logic [2:0] S_DATA   = 3'b011;
  localparam logic [2:0] S_PARITY = 3'b010;
  localparam logic [2:0] S_STOP1  = 3'b110;
  localparam logic [2:0] S_STOP2  = 3'b111;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // data_xor is the XOR-reduction of the payload; odd parity inverts it
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    logic p;
    p = data_xor;
    case (par_typ)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART TX controller.
// ser_bit is the next payload bit to put on the line; ser_done flags the last data bit.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  shift_en,
  input  logic                  cnt_en,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

  // Loading also clears the counter, so it sits at 0 on entry to DATA
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data;
      cnt   <= '0;
    end else begin
      if (shift_en) begin
        if (MSB_FIRST)
          shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        else
          shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
      end
      if (cnt_en)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign ser_bit  = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
  assign ser_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl_param.sv
// UART transmit controller: FSM, config latches, parity and registered TX_OUT/BUSY.
// Define UART_TX_B2B_EN to allow a new frame to start straight out of the last stop bit.
module uart_tx_ctrl_param
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2_EN,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  logic [2:0] state;
  logic       par_en_r;
  logic       stop2_en_r;
  logic       parity_r;
  logic       accept;
  logic       ser_bit;
  logic       ser_done;
  logic       shift_en;
  logic       cnt_en;

`ifdef UART_TX_B2B_EN
  logic last_stop;

  always_comb begin
    last_stop = (state == S_STOP2) || ((state == S_STOP1) && !stop2_en_r);
    accept    = DATA_VALID && ((state == S_IDLE) || last_stop);
  end
`else
  always_comb begin
    accept = DATA_VALID && (state == S_IDLE);
  end
`endif

  // START shifts out bit 0 so the head of the register is always the next bit to send
  assign shift_en = (state == S_START) || (state == S_DATA);
  assign cnt_en   = (state == S_DATA) && !ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_ser (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (accept),
    .data     (P_DATA),
    .shift_en (shift_en),
    .cnt_en   (cnt_en),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_IDLE;
      TX_OUT     <= 1'b1;
      BUSY       <= 1'b0;
      par_en_r   <= 1'b0;
      stop2_en_r <= 1'b0;
      parity_r   <= 1'b0;
    end else if (accept) begin
      state      <= S_START;
      TX_OUT     <= 1'b0;
      BUSY       <= 1'b1;
      par_en_r   <= PAR_EN;
      stop2_en_r <= STOP2_EN;
      parity_r   <= parity_bit(^P_DATA, PAR_TYP);
    end else begin
      case (state)
        S_START: begin
          state  <= S_DATA;
          TX_OUT <= ser_bit;
        end
        S_DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_bit;
          end else if (par_en_r) begin
            state  <= S_PARITY;
            TX_OUT <= parity_r;
          end else begin
            state  <= S_STOP1;
            TX_OUT <= 1'b1;
          end
        end
        S_PARITY: begin
          state  <= S_STOP1;
          TX_OUT <= 1'b1;
        end
        S_STOP1: begin
          TX_OUT <= 1'b1;
          if (stop2_en_r) begin
            state <= S_STOP2;
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        // STOP2 exit and any unreachable code both fall back to idle
        default: begin
          state  <= S_IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl_param.sv
// Testbench for uart_tx_ctrl_param: an 8-bit LSB-first instance and a 5-bit MSB-first instance
// checked against a frame-level reference model; honours UART_TX_B2B_EN for the idle gap.
module tb_uart_tx_ctrl_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] p_data;
  logic        dv;
  logic        par_en;
  logic        par_typ;
  logic        stop2_en;
  logic        use5;
  logic        tx8, busy8, tx5, busy5;
  logic        dv8, dv5;
  logic        tx_sel, busy_sel;

  int compared   = 0;
  int mismatched = 0;

  logic exp_q[$];
  logic obs_tx[$];
  logic obs_busy[$];

  always #5 clk = ~clk;

  assign dv8      = dv & ~use5;
  assign dv5      = dv & use5;
  assign tx_sel   = use5 ? tx5 : tx8;
  assign busy_sel = use5 ? busy5 : busy8;

  uart_tx_ctrl_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(p_data[7:0]), .DATA_VALID(dv8), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .STOP2_EN(stop2_en), .TX_OUT(tx8), .BUSY(busy8)
  );

  uart_tx_ctrl_param #(.DATA_WIDTH(5), .MSB_FIRST(1'b1)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(p_data[4:0]), .DATA_VALID(dv5), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .STOP2_EN(stop2_en), .TX_OUT(tx5), .BUSY(busy5)
  );

  // Reference model: the full list of line bits for one frame
  function automatic void build_frame(input logic [15:0] data, input int w, input bit msb,
                                      input bit pe, input bit pt, input bit s2);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      int idx;
      idx = msb ? (w - 1 - i) : i;
      exp_q.push_back(data[idx]);
      if (data[i]) ones++;
    end
    if (pe) exp_q.push_back(ones[0] ^ pt);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  // Accept one frame, then record n line samples (one per cycle, at the falling edge)
  task automatic send_capture(input logic [15:0] data, input bit pe, input bit pt, input bit s2,
                              input bit sel5, input bit noise, input int n);
    @(negedge clk);
    use5 = sel5; p_data = data; par_en = pe; par_typ = pt; stop2_en = s2; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    obs_tx.delete();
    obs_busy.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx.push_back(tx_sel);
      obs_busy.push_back(busy_sel);
      if (noise) begin
        p_data   = 16'($urandom);
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
        stop2_en = 1'($urandom);
        dv       = (i < n - 2) ? 1'($urandom) : 1'b0;
      end
    end
    dv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; dv = 1'b1; use5 = 1'b0; p_data = 16'h00A5;
    par_en = 1'b1; par_typ = 1'b0; stop2_en = 1'b0;
    repeat (3) @(negedge clk);
    compared += 4;
    if (tx8 !== 1'b1)  begin mismatched++; $display("[TB] FAIL reset_tx8: got %b want 1", tx8); end
    if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy8: got %b want 0", busy8); end
    if (tx5 !== 1'b1)  begin mismatched++; $display("[TB] FAIL reset_tx5: got %b want 1", tx5); end
    if (busy5 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy5: got %b want 0", busy5); end
    dv = 1'b0; rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      compared += 2;
      if (tx8 !== 1'b1)  begin mismatched++; $display("[TB] FAIL idle_tx8: got %b want 1", tx8); end
      if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy8: got %b want 0", busy8); end
    end
  endtask

  task automatic test_frame_a5();
    build_frame(16'h00A5, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    send_capture(16'h00A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_q.size() + 1);
    for (int i = 0; i < obs_tx.size(); i++) begin
      logic et, eb;
      et = (i < exp_q.size()) ? exp_q[i] : 1'b1;
      eb = (i < exp_q.size());
      compared += 2;
      if (obs_tx[i] !== et) begin mismatched++; $display("[TB] FAIL a5_tx bit%0d: got %b want %b", i, obs_tx[i], et); end
      if (obs_busy[i] !== eb) begin mismatched++; $display("[TB] FAIL a5_busy bit%0d: got %b want %b", i, obs_busy[i], eb); end
    end
  endtask

  task automatic test_parity_odd_stop2();
    build_frame(16'h0000, 8, 1'b0, 1'b1, 1'b1, 1'b1);
    send_capture(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13);
    compared += 3;
    if (exp_q.size() != 12) begin mismatched++; $display("[TB] FAIL odd_len: got %0d want 12", exp_q.size()); end
    if (obs_tx[9] !== 1'b1) begin mismatched++; $display("[TB] FAIL odd_parity: got %b want 1", obs_tx[9]); end
    if (obs_busy[12] !== 1'b0) begin mismatched++; $display("[TB] FAIL odd_busy_end: got %b want 0", obs_busy[12]); end
    for (int i = 0; i < 12; i++) begin
      compared += 2;
      if (obs_tx[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL odd_tx bit%0d: got %b want %b", i, obs_tx[i], exp_q[i]); end
      if (obs_busy[i] !== 1'b1) begin mismatched++; $display("[TB] FAIL odd_busy bit%0d: got %b want 1", i, obs_busy[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
`ifdef UART_TX_B2B_EN
    gap = 0;
`else
    gap = 1;
`endif
    build_frame(16'h00FF, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    use5 = 1'b0; p_data = 16'h00FF; par_en = 1'b0; par_typ = 1'b0; stop2_en = 1'b0; dv = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared += 2;
      if (tx8 !== exp_q[i]) begin mismatched++; $display("[TB] FAIL b2b_f1_tx bit%0d: got %b want %b", i, tx8, exp_q[i]); end
      if (busy8 !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_f1_busy bit%0d: got %b want 1", i, busy8); end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      compared += 2;
      if (tx8 !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_gap_tx: got %b want 1", tx8); end
      if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_gap_busy: got %b want 0", busy8); end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) dv = 1'b0;
      compared += 2;
      if (tx8 !== exp_q[i]) begin mismatched++; $display("[TB] FAIL b2b_f2_tx bit%0d: got %b want %b", i, tx8, exp_q[i]); end
      if (busy8 !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_f2_busy bit%0d: got %b want 1", i, busy8); end
    end
    @(negedge clk);
    compared += 2;
    if (tx8 !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_end_tx: got %b want 1", tx8); end
    if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_end_busy: got %b want 0", busy8); end
  endtask

  task automatic test_ignore_busy();
    build_frame(16'h0081, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    use5 = 1'b0; p_data = 16'h0081; par_en = 1'b0; par_typ = 1'b0; stop2_en = 1'b0; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    for (int i = 0; i < 14; i++) begin
      logic et, eb;
      @(negedge clk);
      et = (i < 10) ? exp_q[i] : 1'b1;
      eb = (i < 10);
      compared += 2;
      if (tx8 !== et) begin mismatched++; $display("[TB] FAIL ignore_tx bit%0d: got %b want %b", i, tx8, et); end
      if (busy8 !== eb) begin mismatched++; $display("[TB] FAIL ignore_busy bit%0d: got %b want %b", i, busy8, eb); end
      if (i == 3) begin p_data = 16'h003C; dv = 1'b1; end
      if (i == 4) dv = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    use5 = 1'b0; p_data = 16'h00F0; par_en = 1'b1; par_typ = 1'b1; stop2_en = 1'b1; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    compared += 2;
    if (tx8 !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_tx: got %b want 1", tx8); end
    if (busy8 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b want 0", busy8); end
    build_frame(16'h005A, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    send_capture(16'h005A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_q.size() + 1);
    for (int i = 0; i < obs_tx.size(); i++) begin
      logic et, eb;
      et = (i < exp_q.size()) ? exp_q[i] : 1'b1;
      eb = (i < exp_q.size());
      compared += 2;
      if (obs_tx[i] !== et) begin mismatched++; $display("[TB] FAIL postrst_tx bit%0d: got %b want %b", i, obs_tx[i], et); end
      if (obs_busy[i] !== eb) begin mismatched++; $display("[TB] FAIL postrst_busy bit%0d: got %b want %b", i, obs_busy[i], eb); end
    end
  endtask

  task automatic test_msb_w5();
    build_frame(16'h0013, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_capture(16'h0013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8);
    compared++;
    if (exp_q.size() != 7) begin mismatched++; $display("[TB] FAIL w5_len: got %0d want 7", exp_q.size()); end
    for (int i = 0; i < 8; i++) begin
      logic et, eb;
      et = (i < 7) ? exp_q[i] : 1'b1;
      eb = (i < 7);
      compared += 2;
      if (obs_tx[i] !== et) begin mismatched++; $display("[TB] FAIL w5_tx bit%0d: got %b want %b", i, obs_tx[i], et); end
      if (obs_busy[i] !== eb) begin mismatched++; $display("[TB] FAIL w5_busy bit%0d: got %b want %b", i, obs_busy[i], eb); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      bit sel5, pe, pt, s2;
      logic [15:0] data;
      int w;
      sel5 = 1'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      data = 16'($urandom);
      w = sel5 ? 5 : 8;
      build_frame(data, w, sel5, pe, pt, s2);
      send_capture(data, pe, pt, s2, sel5, 1'b1, exp_q.size() + 1);
      for (int i = 0; i < obs_tx.size(); i++) begin
        logic et, eb;
        et = (i < exp_q.size()) ? exp_q[i] : 1'b1;
        eb = (i < exp_q.size());
        compared += 2;
        if (obs_tx[i] !== et) begin mismatched++; $display("[TB] FAIL rand%0d_tx bit%0d data=%h w=%0d: got %b want %b", f, i, data, w, obs_tx[i], et); end
        if (obs_busy[i] !== eb) begin mismatched++; $display("[TB] FAIL rand%0d_busy bit%0d: got %b want %b", f, i, obs_busy[i], eb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_odd_stop2();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    test_msb_w5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
